gray_counter_param: RTL and testbench



---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray2bin_conv.sv | 24 ++
 rtl/gray_counter_param.sv | 81 ++++++++
 tb/tb_gray_counter_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers shared by the counter and the async FIFO pointers.
// Latency: pure functions, no state.
// Backpressure: not applicable; callers zero-extend narrower values to GRAY_MAX_W.
package gray_pkg;

    // Widest pointer/counter any user of these helpers is expected to need.
    localparam int GRAY_MAX_W = 16;

    typedef logic [GRAY_MAX_W-1:0] gword_t;

    // Binary to Gray: each bit is the XOR of itself and the next higher bit.
    function automatic gword_t bin2gray(input gword_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR running down from the MSB. Zero upper bits
    // contribute nothing, so a zero-extended narrow value converts correctly.
    function automatic gword_t gray2bin(input gword_t g);
        gword_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Width-parametrised Gray-to-binary converter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module gray2bin_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    gword_t gray_ext;
    gword_t bin_ext;

    // Widen to the package word, convert, and keep only the live bits.
    always_comb begin
        gray_ext              = '0;
        gray_ext[WIDTH-1:0]   = gray_i;
        bin_ext               = gray2bin(gray_ext);
        bin_o                 = bin_ext[WIDTH-1:0];
    end

endmodule

// File: rtl/gray_counter_param.sv
// Up/down Gray counter with load, wrap-or-saturate ends and terminal-count flag.
// Latency: one clk from en/load/reset to registered gray_count and bin_count.
// Backpressure: none; en steps once per clk, tc is combinational from state and inputs.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_count,
    output logic [WIDTH-1:0] bin_count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] step_bin;
    logic             at_max;
    logic             at_zero;
    gword_t           step_ext;
    gword_t           step_gray_ext;

    // Load value arrives Gray-coded; the binary view needs the converted form.
    gray2bin_conv #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray_i (load_gray),
        .bin_o  (load_bin)
    );

    assign at_max  = (bin_q == MAX_VAL);
    assign at_zero = (bin_q == '0);

    // Terminal count: an enabled, non-load step about to cross (or sit on) an end.
    assign tc = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

    // Next-state selection: load beats en, en beats hold; saturate freezes at the ends.
    always_comb begin
        step_bin      = up_dn ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
        step_ext      = '0;
        step_ext[WIDTH-1:0] = step_bin;
        step_gray_ext = bin2gray(step_ext);

        bin_d  = bin_q;
        gray_d = gray_q;
        if (load) begin
            bin_d  = load_bin;
            gray_d = load_gray;
        end else if (en && !((SATURATE != 0) && tc)) begin
            bin_d  = step_bin;
            gray_d = step_gray_ext[WIDTH-1:0];
        end
    end

    // Both views update on the same edge so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign gray_count = gray_q;
    assign bin_count  = bin_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param across several parameter sets.
// Latency: expects registered outputs one clk after each driven step.
// Backpressure: none; the driver issues one step per clk, the monitor consumes one per clk.
module tb_gray_counter_param;

    localparam int N = 5;
    localparam int PW [N] = '{4, 4, 4, 6, 6};
    localparam int PS [N] = '{0, 1, 0, 0, 1};
    localparam int PR [N] = '{0, 0, 5, 0, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst_a, en_a, ud_a, ld_a, tc_a;
    logic [N-1:0][15:0] lg_a, g_a, b_a;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        logic [PW[gi]-1:0] gq, bq;
        gray_counter_param #(
            .WIDTH     (PW[gi]),
            .SATURATE  (PS[gi]),
            .RESET_VAL (PR[gi])
        ) u_dut (
            .clk        (clk),
            .reset      (rst_a[gi]),
            .en         (en_a[gi]),
            .up_dn      (ud_a[gi]),
            .load       (ld_a[gi]),
            .load_gray  (lg_a[gi][PW[gi]-1:0]),
            .gray_count (gq),
            .bin_count  (bq),
            .tc         (tc_a[gi])
        );
        assign g_a[gi] = 16'(gq);
        assign b_a[gi] = 16'(bq);
    end

    typedef struct {
        int d;
        bit tc;
        int gray;
        int bin;
        bit stepped;
    } item_t;

    item_t q[$];
    int    m  [N];
    int    pg [N];
    int    pb [N];
    bit    pv [N];
    int    hist[$];
    bit    rec;
    int    total = 0;
    int    bad   = 0;

    function automatic int gof(int v);
        return v ^ (v >> 1);
    endfunction

    // Reverse lookup: the binary value whose Gray code matches.
    function automatic int g2b(int g, int w);
        for (int v = 0; v < (1 << w); v++) begin
            if (gof(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Drive one clock of stimulus to DUT d and push the expected outcome.
    task automatic step(int d, bit r, bit e, bit u, bit l, int lg);
        int    mx;
        int    old;
        item_t it;
        mx  = (1 << PW[d]) - 1;
        old = m[d];
        @(negedge clk);
        rst_a = '0; en_a = '0; ud_a = '0; ld_a = '0; lg_a = '0;
        rst_a[d] = r; en_a[d] = e; ud_a[d] = u; ld_a[d] = l; lg_a[d] = 16'(lg);
        it.d  = d;
        it.tc = e && !l && ((u && old == mx) || (!u && old == 0));
        if (r)      m[d] = PR[d];
        else if (l) m[d] = g2b(lg, PW[d]);
        else if (e) begin
            if (u) m[d] = (old == mx) ? ((PS[d] != 0) ? mx : 0) : old + 1;
            else   m[d] = (old == 0)  ? ((PS[d] != 0) ? 0 : mx) : old - 1;
        end
        it.gray    = gof(m[d]);
        it.bin     = m[d];
        it.stepped = !r && !l && e && (m[d] != old);
        q.push_back(it);
    endtask

    task automatic drain();
        @(negedge clk);
        rst_a = '0; en_a = '0; ud_a = '0; ld_a = '0; lg_a = '0;
        @(negedge clk);
    endtask

    // Monitor: consume one expected item per tracked cycle and compare.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                it = q.pop_front();
                if (pv[it.d]) begin
                    chk("pre_edge_gray", int'(g_a[it.d]), pg[it.d]);
                    chk("pre_edge_bin",  int'(b_a[it.d]), pb[it.d]);
                end
                chk("tc", int'(tc_a[it.d]), int'(it.tc));
                @(posedge clk);
                #1;
                chk("gray", int'(g_a[it.d]), it.gray);
                chk("bin",  int'(b_a[it.d]), it.bin);
                chk("bin_vs_gray", int'(b_a[it.d]), g2b(int'(g_a[it.d]), PW[it.d]));
                if (it.stepped && pv[it.d])
                    chk("one_bit_step", $countones(g_a[it.d] ^ 16'(pg[it.d])), 1);
                pg[it.d] = it.gray;
                pb[it.d] = it.bin;
                pv[it.d] = 1'b1;
                if (rec && it.d == 0) hist.push_back(int'(g_a[0]));
            end
        end
    end

    initial begin
        int tbl [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
        rst_a = '1; en_a = '0; ud_a = '0; ld_a = '0; lg_a = '0;
        rec = 1'b0;
        for (int d = 0; d < N; d++) begin
            m[d]  = PR[d];
            pv[d] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Full up cycle at width 4 with wrap, checked against the literal sequence.
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        rec = 1'b1;
        repeat (16) step(0, 0, 1, 1, 0, 0);
        drain();
        rec = 1'b0;
        chk("t1_hist_len", hist.size(), 17);
        for (int i = 0; i < 17 && i < hist.size(); i++) chk("t1_gray_seq", hist[i], tbl[i]);

        // Down from reset wraps to max, then keeps descending.
        step(0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);

        // Load wins over en, then counting resumes from the loaded value.
        step(0, 0, 1, 1, 1, 'b1010);
        step(0, 0, 1, 1, 0, 0);

        // Reset mid-count with en high.
        step(0, 1, 0, 0, 0, 0);
        repeat (6) step(0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);

        // Non-zero reset value.
        step(2, 1, 0, 0, 0, 0);
        step(2, 0, 1, 1, 0, 0);
        step(2, 1, 1, 1, 0, 0);
        step(2, 0, 1, 0, 0, 0);

        // Saturate at both ends and step away from max.
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 'b1000);
        repeat (3) step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0);

        // Random traffic at width 6, wrap mode.
        step(3, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++)
            step(3, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 63)));

        // Random traffic at width 6, saturate mode, biased to reach both ends.
        step(4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++)
            step(4, 1'b0, $urandom_range(0, 4) != 0,
                 (i < 300) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2),
                 $urandom_range(0, 29) == 0, int'($urandom_range(0, 63)));

        drain();
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
